axis_decimator_mc: RTL

- Parametrised multi-channel successor to the single-channel sample-drop decimator in the AD9226 capture path.
- Sits between the ADC sample formatter and the AXI-Stream DMA packer.
- Reduces the rate by a runtime ratio R = decimate_reg+1, in one of three modes: pick, boxcar average (sum and shift), or peak-hold.
- Provides correct AXI-Stream backpressure, a registered output, and per-frame tlast generation.

---
 rtl/axis_decimator_mc.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/axis_decimator_mc.sv
// Multi-channel AXI-Stream decimator: pick / boxcar-average / peak-hold over
// runtime groups of R = decimate_reg+1 beats, with registered output and tlast.
module axis_decimator_mc #(
  parameter int DATA_WIDTH  = 12,
  parameter int NUM_CH      = 2,
  parameter int RATIO_WIDTH = 16,
  parameter int FRAME_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [1:0]                   mode,
  input  logic [RATIO_WIDTH-1:0]       decimate_reg,
  input  logic [4:0]                   shift_reg,
  input  logic [FRAME_WIDTH-1:0]       frame_len,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic                         in_data_valid,
  output logic                         in_data_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic                         out_data_valid,
  input  logic                         out_data_ready,
  output logic                         out_data_last,
  output logic                         sat_flag
);

  localparam int ACC_W = DATA_WIDTH + RATIO_WIDTH;
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FIRST, ACC} state_t;
  typedef enum logic [1:0] {M_PICK, M_AVG, M_MAX, M_RSVD} mode_t;

  state_t                          state_q, state_d;
  mode_t                           mode_s, cur_mode;
  logic [4:0]                      shift_s, cur_shift;
  logic [RATIO_WIDTH-1:0]          ratio_s, cur_ratio, cnt_q, cnt_next;
  logic [NUM_CH-1:0][ACC_W-1:0]    acc_q, acc_upd;
  logic signed [ACC_W-1:0]         samp, cur, shifted;
  logic [NUM_CH*DATA_WIDTH-1:0]    res_bus;
  logic                            any_clip, stall, accept, complete, xfer, last_new;
  logic [FRAME_WIDTH-1:0]          frame_cnt, frame_adv, beat_idx, flen_s, flen_use;

  // Control: the first beat of a group uses the live settings, later beats the shadows.
  always_comb begin
    stall         = out_data_valid && !out_data_ready;
    xfer          = out_data_valid && out_data_ready;
    in_data_ready = enable && (state_q != IDLE) && !stall;
    accept        = in_data_valid && in_data_ready;
    cur_mode      = (state_q == FIRST) ? mode_t'(mode) : mode_s;
    cur_shift     = (state_q == FIRST) ? shift_reg : shift_s;
    cur_ratio     = (state_q == FIRST) ? decimate_reg : ratio_s;
    cnt_next      = (state_q == FIRST) ? '0 : cnt_q + RATIO_WIDTH'(1);
    complete      = accept && (cnt_next == cur_ratio);
    state_d       = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = FIRST;
      FIRST:   if (accept && !complete) state_d = ACC;
      ACC:     if (complete) state_d = FIRST;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // Per-channel accumulator update and result formatting for the completing beat.
  always_comb begin
    acc_upd  = acc_q;
    res_bus  = '0;
    any_clip = 1'b0;
    samp     = '0;
    cur      = '0;
    shifted  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      samp = {{RATIO_WIDTH{in_data[c*DATA_WIDTH+DATA_WIDTH-1]}}, in_data[c*DATA_WIDTH +: DATA_WIDTH]};
      cur  = acc_q[c];
      if (state_q == FIRST) begin
        acc_upd[c] = samp;
      end else begin
        case (cur_mode)
          M_AVG:   acc_upd[c] = cur + samp;
          M_MAX:   if (samp > cur) acc_upd[c] = samp;
          default: ;
        endcase
      end
      shifted = $signed(acc_upd[c]) >>> cur_shift;
      if (cur_mode == M_AVG) begin
        if (shifted > SAT_HI) begin
          res_bus[c*DATA_WIDTH +: DATA_WIDTH] = SAT_HI[DATA_WIDTH-1:0];
          any_clip = 1'b1;
        end else if (shifted < SAT_LO) begin
          res_bus[c*DATA_WIDTH +: DATA_WIDTH] = SAT_LO[DATA_WIDTH-1:0];
          any_clip = 1'b1;
        end else begin
          res_bus[c*DATA_WIDTH +: DATA_WIDTH] = shifted[DATA_WIDTH-1:0];
        end
      end else begin
        res_bus[c*DATA_WIDTH +: DATA_WIDTH] = acc_upd[c][DATA_WIDTH-1:0];
      end
    end
  end

  // The frame counter advances on transfer; a beat loaded in the same cycle as
  // the previous one leaves must see the already-advanced index.
  always_comb begin
    frame_adv = out_data_last ? '0 : frame_cnt + FRAME_WIDTH'(1);
    beat_idx  = xfer ? frame_adv : frame_cnt;
    flen_use  = (beat_idx == '0) ? frame_len : flen_s;
    last_new  = (beat_idx == flen_use);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      mode_s         <= M_PICK;
      shift_s        <= '0;
      ratio_s        <= '0;
      cnt_q          <= '0;
      acc_q          <= '0;
      frame_cnt      <= '0;
      flen_s         <= '0;
      out_data       <= '0;
      out_data_valid <= 1'b0;
      out_data_last  <= 1'b0;
      sat_flag       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && state_q == FIRST) begin
        mode_s  <= mode_t'(mode);
        shift_s <= shift_reg;
        ratio_s <= decimate_reg;
      end
      if (accept) begin
        cnt_q <= cnt_next;
        acc_q <= acc_upd;
      end
      if (xfer) frame_cnt <= frame_adv;
      if (complete) begin
        out_data       <= res_bus;
        out_data_valid <= 1'b1;
        out_data_last  <= last_new;
        if (beat_idx == '0) flen_s <= frame_len;
        if (cur_mode == M_AVG && any_clip) sat_flag <= 1'b1;
      end else if (xfer) begin
        out_data_valid <= 1'b0;
        out_data_last  <= 1'b0;
      end
    end
  end

endmodule
